// File: rtl/mem_loader_pkg.sv
// Shared encodings for the program-image loader: FSM states, bus widths and
// the byte-count to write-strobe table used for the final partial word.
package mem_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [STRB_W-1:0] WSTRB_FULL = 4'b1111;

  // Lanes are filled from byte 0 upward, so a word holding n bytes enables the low n lanes.
  function automatic logic [STRB_W-1:0] strobe_for(input logic [2:0] count);
    case (count)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return WSTRB_FULL;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Control, byte-stream and picorv32-style memory bus signals of the loader.
// The loader takes the master view; whatever surrounds it takes the slave view.
interface mem_loader_if #(parameter int LEN_W = 16);
  import mem_loader_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  byte_len;
  logic              busy;
  logic              done;
  logic              error;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_instr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  modport master (
    input  start, base_addr, byte_len, in_valid, in_data, mem_ready,
    output busy, done, error, in_ready, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr
  );

  modport slave (
    output start, base_addr, byte_len, in_valid, in_data, mem_ready,
    input  busy, done, error, in_ready, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Packs accepted bytes little-endian into one 32-bit word and reports how many
// lanes are filled, together with the matching write strobe.
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [2:0]        o_count
);

  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_count;
  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = DATA_W'(i_byte) << {r_count[1:0], 3'b000};

  // Lanes start at zero, so merging by OR leaves unused lanes of a partial word cleared.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_push && (r_count < 3'd4)) begin
      r_data  <= r_data | w_shifted;
      r_count <= r_count + 3'd1;
    end
  end

  assign o_wdata = r_data;
  assign o_wstrb = strobe_for(r_count);
  assign o_count = r_count;

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into memory as little-endian words over the picorv32 native bus,
// owning the memory port while a program image is being loaded.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic        clk,
  input logic        reset,
  mem_loader_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [TMR_W-1:0]  r_timer;
  logic              r_error;

  logic              w_accept;
  logic              w_word_ready;
  logic              w_clear;
  logic [2:0]        w_count;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_accept     = (r_state == S_COLLECT) && bus.in_valid;
  assign w_word_ready = w_accept && ((w_count == 3'd3) || (r_remain == LEN_W'(1)));
  assign w_clear      = (r_state == S_IDLE) || (r_state == S_GAP);

  mem_loader_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_accept),
    .i_byte  (bus.in_data),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb),
    .o_count (w_count)
  );

  // A write that sees mem_ready on its last allowed cycle still completes rather than aborting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_timer  <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr   <= {bus.base_addr[ADDR_W-1:2], 2'b00};
            r_remain <= bus.byte_len;
            r_error  <= 1'b0;
            r_state  <= (bus.byte_len == '0) ? S_FINISH : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            if (r_remain != '0) r_remain <= r_remain - LEN_W'(1);
            if (w_word_ready) begin
              r_timer <= '0;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            r_state <= S_GAP;
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_error <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_GAP: begin
          r_addr  <= r_addr + 32'd4;
          r_state <= (r_remain != '0) ? S_COLLECT : S_FINISH;
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_COLLECT) || (r_state == S_WRITE) || (r_state == S_GAP);
  assign bus.done      = (r_state == S_FINISH);
  assign bus.error     = r_error;
  assign bus.in_ready  = (r_state == S_COLLECT);
  assign bus.mem_valid = (r_state == S_WRITE);
  assign bus.mem_instr = 1'b0;
  assign bus.mem_wstrb = (r_state == S_WRITE) ? w_wstrb : '0;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_addr  = r_addr;

endmodule
